// File: rtl/erx_sysmux.sv
// Merges the elink rx write, read-request and read-response streams onto one emesh port.
// Round-robin grant into a single output register (latency 1); waits assert while the output is stalled or another channel holds the grant.
module erx_sysmux #(
  parameter int PW = 104,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rxwr_access,
  input  logic [PW-1:0] rxwr_packet,
  output logic          rxwr_wait,
  input  logic          rxrd_access,
  input  logic [PW-1:0] rxrd_packet,
  output logic          rxrd_wait,
  input  logic          rxrr_access,
  input  logic [PW-1:0] rxrr_packet,
  output logic          rxrr_wait,
  output logic          mux_access,
  output logic [PW-1:0] mux_packet,
  input  logic          mux_wait,
  input  logic          cnt_clear,
  output logic [CW-1:0] cnt_wr,
  output logic [CW-1:0] cnt_rd,
  output logic [CW-1:0] cnt_rr
);

  typedef enum logic [1:0] {
    PTR_WR = 2'd0,
    PTR_RD = 2'd1,
    PTR_RR = 2'd2
  } ptr_t;

  ptr_t                 ptr_q;
  ptr_t                 ptr_d;
  logic                 free;
  logic [2:0]           req;
  logic [2:0]           gnt;
  logic [2:0][CW-1:0]   cnt_q;

  assign free = ~mux_access | ~mux_wait;
  assign req  = {rxrr_access, rxrd_access, rxwr_access};

  // Pointer names the first channel to consider; it advances past the winner.
  always_comb begin
    gnt   = 3'b000;
    ptr_d = ptr_q;
    if (free) begin
      case (ptr_q)
        PTR_RD:  gnt = req[1] ? 3'b010 : req[2] ? 3'b100 : req[0] ? 3'b001 : 3'b000;
        PTR_RR:  gnt = req[2] ? 3'b100 : req[0] ? 3'b001 : req[1] ? 3'b010 : 3'b000;
        default: gnt = req[0] ? 3'b001 : req[1] ? 3'b010 : req[2] ? 3'b100 : 3'b000;
      endcase
      if (gnt[0])      ptr_d = PTR_RD;
      else if (gnt[1]) ptr_d = PTR_RR;
      else if (gnt[2]) ptr_d = PTR_WR;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q      <= PTR_WR;
      mux_access <= 1'b0;
      mux_packet <= '0;
    end else if (free) begin
      ptr_q      <= ptr_d;
      mux_access <= |gnt;
      if (gnt[0])      mux_packet <= rxwr_packet;
      else if (gnt[1]) mux_packet <= rxrd_packet;
      else if (gnt[2]) mux_packet <= rxrr_packet;
    end
  end

  assign rxwr_wait = ~free | (rxwr_access & ~gnt[0]);
  assign rxrd_wait = ~free | (rxrd_access & ~gnt[1]);
  assign rxrr_wait = ~free | (rxrr_access & ~gnt[2]);

  // A grant is exactly an accepted transfer, so it drives the counters directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (cnt_clear)
          cnt_q[i] <= '0;
        else if (gnt[i] && (cnt_q[i] != {CW{1'b1}}))
          cnt_q[i] <= cnt_q[i] + CW'(1);
      end
    end
  end

  assign cnt_wr = cnt_q[0];
  assign cnt_rd = cnt_q[1];
  assign cnt_rr = cnt_q[2];

endmodule

// File: tb/tb_erx_sysmux.sv
// Bench for erx_sysmux: directed stream scenarios checked each cycle against a
// queue/arithmetic model of the round-robin merge, plus literal expectations.
module tb_erx_sysmux;
  localparam int PW   = 104;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          rxwr_access, rxrd_access, rxrr_access;
  logic [PW-1:0] rxwr_packet, rxrd_packet, rxrr_packet;
  logic          rxwr_wait, rxrd_wait, rxrr_wait;
  logic          mux_access;
  logic [PW-1:0] mux_packet;
  logic          mux_wait;
  logic          cnt_clear;
  logic [CW-1:0] cnt_wr, cnt_rd, cnt_rr;

  erx_sysmux #(.PW(PW), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .rxwr_access(rxwr_access), .rxwr_packet(rxwr_packet), .rxwr_wait(rxwr_wait),
    .rxrd_access(rxrd_access), .rxrd_packet(rxrd_packet), .rxrd_wait(rxrd_wait),
    .rxrr_access(rxrr_access), .rxrr_packet(rxrr_packet), .rxrr_wait(rxrr_wait),
    .mux_access(mux_access), .mux_packet(mux_packet), .mux_wait(mux_wait),
    .cnt_clear(cnt_clear), .cnt_wr(cnt_wr), .cnt_rd(cnt_rd), .cnt_rr(cnt_rr)
  );

  always #5 clk = ~clk;

  int            total = 0;
  int            bad   = 0;
  logic [PW-1:0] base [3];
  int            seq  [3];
  logic [PW-1:0] outq [$];

  // Model state: registered output, next channel to consider, counters.
  logic          m_acc;
  logic [PW-1:0] m_pkt;
  int            m_ptr;
  int            m_cnt [3];

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [2:0]    acc;
    logic [2:0]    w_exp;
    logic [PW-1:0] pk [3];
    logic          fr;
    int            g;
    int            c;
    if (reset) begin
      chk("rst_access", PW'(mux_access), PW'(0));
      chk("rst_packet", mux_packet, PW'(0));
      chk("rst_cnts", PW'({cnt_rr, cnt_rd, cnt_wr}), PW'(0));
      m_acc = 1'b0;
      m_pkt = '0;
      m_ptr = 0;
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    end else begin
      acc   = {rxrr_access, rxrd_access, rxwr_access};
      pk[0] = rxwr_packet;
      pk[1] = rxrd_packet;
      pk[2] = rxrr_packet;
      chk("mux_access", PW'(mux_access), PW'(m_acc));
      if (m_acc) chk("mux_packet", mux_packet, m_pkt);
      chk("cnt_wr", PW'(cnt_wr), PW'(m_cnt[0]));
      chk("cnt_rd", PW'(cnt_rd), PW'(m_cnt[1]));
      chk("cnt_rr", PW'(cnt_rr), PW'(m_cnt[2]));
      fr = !m_acc || !mux_wait;
      g  = -1;
      if (fr) begin
        for (int k = 0; k < 3; k++) begin
          c = (m_ptr + k) % 3;
          if (g < 0 && acc[c]) g = c;
        end
      end
      for (int i = 0; i < 3; i++) w_exp[i] = !fr || (acc[i] && g != i);
      chk("waits", PW'({rxrr_wait, rxrd_wait, rxwr_wait}), PW'(w_exp));
      if (m_acc && !mux_wait) outq.push_back(m_pkt);
      if (cnt_clear) begin
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
      end else if (g >= 0 && m_cnt[g] < CMAX) begin
        m_cnt[g]++;
      end
      if (g >= 0) seq[g]++;
      if (fr) begin
        m_acc = (g >= 0);
        if (g >= 0) begin
          m_pkt = pk[g];
          m_ptr = (g + 1) % 3;
        end
      end
    end
  end

  task automatic drive(input logic [2:0] en, input logic mw, input logic clr);
    rxwr_access = en[0];
    rxrd_access = en[1];
    rxrr_access = en[2];
    rxwr_packet = base[0] ^ PW'(seq[0]);
    rxrd_packet = base[1] ^ PW'(seq[1]);
    rxrr_packet = base[2] ^ PW'(seq[2]);
    mux_wait    = mw;
    cnt_clear   = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [2:0] en, input logic mw, input logic clr);
    drive(en, mw, clr);
    tick();
  endtask

  task automatic clear_seq();
    for (int i = 0; i < 3; i++) seq[i] = 0;
  endtask

  initial begin
    int s0;
    base[0] = {13{8'hA5}};
    base[1] = {13{8'h3C}};
    base[2] = {13{8'h96}};
    clear_seq();
    reset = 1'b1;
    drive(3'b000, 1'b0, 1'b0);
    repeat (2) tick();
    chk("init_access", PW'(mux_access), PW'(0));
    chk("init_packet", mux_packet, PW'(0));
    reset = 1'b0;

    // Single write packet passes straight through.
    drive(3'b001, 1'b0, 1'b0);
    #1 chk("t1_wr_wait", PW'(rxwr_wait), PW'(0));
    tick();
    chk("t1_access", PW'(mux_access), PW'(1));
    chk("t1_packet", mux_packet, {13{8'hA5}});
    chk("t1_cnt_wr", PW'(cnt_wr), PW'(1));
    cyc(3'b000, 1'b0, 1'b0);

    // All three active from reset: strict rotation WR, RD, RR.
    reset = 1'b1;
    cyc(3'b000, 1'b0, 1'b0);
    reset = 1'b0;
    clear_seq();
    outq.delete();
    repeat (6) cyc(3'b111, 1'b0, 1'b0);
    cyc(3'b000, 1'b0, 1'b0);
    chk("t2_count", PW'(outq.size()), PW'(6));
    for (int i = 0; i < 6 && i < outq.size(); i++)
      chk("t2_order", outq[i], base[i % 3] ^ PW'(i / 3));
    chk("t2_cnts", PW'({cnt_rr, cnt_rd, cnt_wr}), PW'({4'd2, 4'd2, 4'd2}));

    // Output stalled for 4 cycles with everyone requesting.
    outq.delete();
    cyc(3'b111, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(3'b111, 1'b1, 1'b0);
      #1 chk("t3_waits", PW'({rxrr_wait, rxrd_wait, rxwr_wait}), PW'(3'b111));
      tick();
      chk("t3_hold_pkt", mux_packet, base[0] ^ PW'(2));
      chk("t3_hold_cnt", PW'({cnt_rr, cnt_rd, cnt_wr}), PW'({4'd2, 4'd2, 4'd3}));
    end
    cyc(3'b111, 1'b0, 1'b0);
    cyc(3'b111, 1'b0, 1'b0);
    cyc(3'b000, 1'b0, 1'b0);
    chk("t3_count", PW'(outq.size()), PW'(3));
    for (int i = 0; i < 3 && i < outq.size(); i++)
      chk("t3_order", outq[i], base[i] ^ PW'(2));

    // Pointer at RD, only RR requesting: back-to-back grants.
    cyc(3'b000, 1'b0, 1'b1);
    cyc(3'b001, 1'b0, 1'b0);
    cyc(3'b000, 1'b0, 1'b0);
    outq.delete();
    s0 = seq[2];
    for (int i = 0; i < 5; i++) begin
      cyc(3'b100, 1'b0, 1'b0);
      chk("t4_no_bubble", PW'(mux_access), PW'(1));
      chk("t4_packet", mux_packet, base[2] ^ PW'(s0 + i));
    end
    cyc(3'b000, 1'b0, 1'b0);
    chk("t4_count", PW'(outq.size()), PW'(5));
    chk("t4_cnt_rr", PW'(cnt_rr), PW'(5));
    chk("t4_cnt_wr", PW'(cnt_wr), PW'(1));

    // Counter saturation, then clear beating a same-cycle increment.
    cyc(3'b000, 1'b0, 1'b1);
    repeat (20) cyc(3'b001, 1'b0, 1'b0);
    chk("t5_saturate", PW'(cnt_wr), PW'(15));
    cyc(3'b001, 1'b0, 1'b1);
    chk("t5_clear_wins", PW'(cnt_wr), PW'(0));
    cyc(3'b000, 1'b0, 1'b0);

    // Reset during a stall, with the pointer away from WR.
    cyc(3'b111, 1'b0, 1'b0);
    cyc(3'b111, 1'b1, 1'b0);
    chk("t6_stalled", PW'(mux_access), PW'(1));
    reset = 1'b1;
    #1;
    chk("t6_async_drop", PW'(mux_access), PW'(0));
    chk("t6_cnts", PW'({cnt_rr, cnt_rd, cnt_wr}), PW'(0));
    cyc(3'b111, 1'b1, 1'b0);
    reset = 1'b0;
    clear_seq();
    cyc(3'b111, 1'b0, 1'b0);
    chk("t6_first_wr", mux_packet, base[0]);
    chk("t6_access", PW'(mux_access), PW'(1));
    cyc(3'b000, 1'b0, 1'b0);
    cyc(3'b000, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
